// File: rtl/tex_req_arbiter.sv
// Round-robin arbiter funnelling fragment-shader texture requests into one texture unit,
// with an in-order tag FIFO that routes each returned texel back to its requester.
module tex_req_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int VEC_SIZE        = 4,
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     i_req_u_coord,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     i_req_v_coord,
    output logic [NUM_REQ-1:0]                     o_req_ready,
    output logic                                   o_tex_req_valid,
    output logic [DATA_WIDTH-1:0]                  o_tex_u_coord,
    output logic [DATA_WIDTH-1:0]                  o_tex_v_coord,
    input  logic                                   i_tex_req_ready,
    input  logic                                   i_texel_valid,
    input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]    i_texel_color,
    output logic [NUM_REQ-1:0]                     o_texel_valid,
    output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]    o_texel_color,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
    output logic                                   o_err_unexpected
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

    logic [IDX_W-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                        count_q, count_d;
    logic [NUM_REQ-1:0]                      texel_vld_q, texel_vld_d;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]     texel_color_q, texel_color_d;
    logic                                    err_q, err_d;
    logic [IDX_W-1:0]                        tag_mem_q [MAX_OUTSTANDING];

    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic               grant_found;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] head_oh;
    logic               full;
    logic               fifo_empty;
    logic               tex_req_valid;
    logic               issue;
    logic               pop;

    // Search starts one past the last issued requester so every requester gets a turn.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && i_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign full          = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty    = (count_q == '0);
    assign tex_req_valid = !rst && grant_found && !full;
    assign issue         = tex_req_valid && i_tex_req_ready;
    assign pop           = i_texel_valid && !fifo_empty;

    always_comb begin
        grant_oh = '0;
        if (tex_req_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        head_oh = '0;
        head_oh[tag_mem_q[rd_ptr_q]] = 1'b1;
    end

    assign o_req_ready     = grant_oh & {NUM_REQ{i_tex_req_ready}};
    assign o_tex_req_valid = tex_req_valid;
    assign o_tex_u_coord   = tex_req_valid ? i_req_u_coord[grant_idx] : '0;
    assign o_tex_v_coord   = tex_req_valid ? i_req_v_coord[grant_idx] : '0;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        texel_vld_d   = '0;
        texel_color_d = texel_color_q;
        err_d         = err_q;
        if (issue) begin
            rr_ptr_d = grant_idx;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + 1'b1;
            texel_vld_d   = head_oh;
            texel_color_d = i_texel_color;
        end
        if (i_texel_valid && fifo_empty) begin
            err_d = 1'b1;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Return stage: texel and its one-hot route are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            texel_vld_q   <= '0;
            texel_color_q <= '0;
            err_q         <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            texel_vld_q   <= texel_vld_d;
            texel_color_q <= texel_color_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign o_texel_valid    = texel_vld_q;
    assign o_texel_color    = texel_color_q;
    assign o_outstanding    = count_q;
    assign o_err_unexpected = err_q;

endmodule

// File: tb/tb_tex_req_arbiter.sv
// Scoreboard bench for tex_req_arbiter: expected grants are queued by the stimulus,
// issued tags and returned texels are tracked by a small in-order model.
module tb_tex_req_arbiter;

    localparam int DW = 32;
    localparam int VS = 4;
    localparam int NR = 4;
    localparam int MO = 4;
    localparam int CW = $clog2(MO+1);
    localparam int CK = VS*DW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NR-1:0]           i_req_valid;
    logic [NR-1:0][DW-1:0]   i_req_u_coord;
    logic [NR-1:0][DW-1:0]   i_req_v_coord;
    logic [NR-1:0]           o_req_ready;
    logic                    o_tex_req_valid;
    logic [DW-1:0]           o_tex_u_coord;
    logic [DW-1:0]           o_tex_v_coord;
    logic                    i_tex_req_ready;
    logic                    i_texel_valid;
    logic [VS-1:0][DW-1:0]   i_texel_color;
    logic [NR-1:0]           o_texel_valid;
    logic [VS-1:0][DW-1:0]   o_texel_color;
    logic [CW-1:0]           o_outstanding;
    logic                    o_err_unexpected;

    tex_req_arbiter #(
        .DATA_WIDTH(DW), .VEC_SIZE(VS), .NUM_REQ(NR), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_u_coord(i_req_u_coord), .i_req_v_coord(i_req_v_coord),
        .o_req_ready(o_req_ready), .o_tex_req_valid(o_tex_req_valid),
        .o_tex_u_coord(o_tex_u_coord), .o_tex_v_coord(o_tex_v_coord),
        .i_tex_req_ready(i_tex_req_ready), .i_texel_valid(i_texel_valid),
        .i_texel_color(i_texel_color), .o_texel_valid(o_texel_valid),
        .o_texel_color(o_texel_color), .o_outstanding(o_outstanding),
        .o_err_unexpected(o_err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] vld;
        logic [CK-1:0] col;
    } ret_t;

    int      exp_grant_q[$];
    int      tag_q[$];
    ret_t    ret_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    logic    exp_err = 1'b0;
    logic [CK-1:0] last_col = '0;
    ret_t    mon_r;
    int      mon_g;

    task automatic check_eq(input string tag, input logic [CK-1:0] act, input logic [CK-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_color();
        for (int c = 0; c < VS; c++) i_texel_color[c] = $urandom();
    endtask

    // Monitor on the falling edge: registered outputs first, then returns, then issues.
    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_tex_valid", CK'(o_tex_req_valid), CK'(0));
            check_eq("rst_req_ready", CK'(o_req_ready), CK'(0));
            tag_q.delete();
            ret_q.delete();
            exp_err  = 1'b0;
            last_col = '0;
        end else begin
            check_eq("outstanding", CK'(o_outstanding), CK'(tag_q.size()));
            check_eq("err_flag", CK'(o_err_unexpected), CK'(exp_err));
            if (ret_q.size() > 0) begin
                mon_r = ret_q.pop_front();
                check_eq("texel_route", CK'(o_texel_valid), CK'(mon_r.vld));
                check_eq("texel_color", o_texel_color, mon_r.col);
                last_col = mon_r.col;
            end else begin
                check_eq("texel_idle", CK'(o_texel_valid), CK'(0));
                check_eq("texel_hold", o_texel_color, last_col);
            end
            if (i_texel_valid) begin
                if (tag_q.size() > 0) begin
                    mon_g     = tag_q.pop_front();
                    mon_r.vld = NR'(1) << mon_g;
                    mon_r.col = i_texel_color;
                    ret_q.push_back(mon_r);
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (o_tex_req_valid && i_tex_req_ready) begin
                if (exp_grant_q.size() == 0) begin
                    check_eq("unexpected_issue", CK'(o_req_ready), CK'(0));
                end else begin
                    mon_g = exp_grant_q.pop_front();
                    check_eq("grant", CK'(o_req_ready), CK'(NR'(1) << mon_g));
                    check_eq("grant_u", CK'(o_tex_u_coord), CK'(i_req_u_coord[mon_g]));
                    check_eq("grant_v", CK'(o_tex_v_coord), CK'(i_req_v_coord[mon_g]));
                    tag_q.push_back(mon_g);
                end
            end else if (!o_tex_req_valid) begin
                check_eq("idle_u", CK'(o_tex_u_coord), CK'(0));
                check_eq("idle_v", CK'(o_tex_v_coord), CK'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        i_req_valid     = '0;
        i_tex_req_ready = 1'b1;
        i_texel_valid   = 1'b0;
        i_texel_color   = '0;
        for (int i = 0; i < NR; i++) begin
            i_req_u_coord[i] = DW'(32'h100 + i);
            i_req_v_coord[i] = DW'(32'h200 + i);
        end
        i_req_u_coord[2] = 32'h10;
        i_req_v_coord[2] = 32'h20;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check_eq("reset_count", CK'(o_outstanding), CK'(0));
        check_eq("reset_color", o_texel_color, CK'(0));

        // Single requester, texel back three cycles after issue.
        i_req_valid = 4'b0100;
        exp_grant_q.push_back(2);
        #1;
        check_eq("single_u", CK'(o_tex_u_coord), CK'(32'h10));
        check_eq("single_v", CK'(o_tex_v_coord), CK'(32'h20));
        check_eq("single_ready", CK'(o_req_ready), CK'(4'b0100));
        step();
        i_req_valid = '0;
        step();
        step();
        i_texel_valid = 1'b1;
        for (int c = 0; c < VS; c++) i_texel_color[c] = 32'hAABBCCDD;
        step();
        i_texel_valid = 1'b0;
        #1;
        check_eq("single_ret_vld", CK'(o_texel_valid), CK'(4'b0100));
        check_eq("single_ret_col", o_texel_color, {VS{32'hAABBCCDD}});

        // All four requesting, one issue and one return per cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req_valid = 4'b1111;
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        exp_grant_q.push_back(3);
        exp_grant_q.push_back(0);
        for (int k = 0; k < 6; k++) begin
            step();
            i_texel_valid = (k < 5);
            if (k == 4) i_req_valid = '0;
            rand_color();
        end

        // Back-pressure holds the grant on requester 1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req_valid     = 4'b1010;
        i_tex_req_ready = 1'b0;
        #1;
        check_eq("hold_u_first", CK'(o_tex_u_coord), CK'(i_req_u_coord[1]));
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("hold_u", CK'(o_tex_u_coord), CK'(i_req_u_coord[1]));
            check_eq("hold_ready", CK'(o_req_ready), CK'(0));
        end
        i_tex_req_ready = 1'b1;
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(3);
        step();
        step();
        i_req_valid = '0;

        // Fill to the limit, then a return must not allow a same-cycle issue.
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req_valid = 4'b0001;
        repeat (4) exp_grant_q.push_back(0);
        repeat (4) step();
        check_eq("full_count", CK'(o_outstanding), CK'(4));
        check_eq("full_blocks", CK'(o_tex_req_valid), CK'(0));
        step();
        i_texel_valid = 1'b1;
        rand_color();
        exp_grant_q.push_back(0);
        #1;
        check_eq("full_pop_no_issue", CK'(o_tex_req_valid), CK'(0));
        step();
        i_texel_valid = 1'b0;
        check_eq("after_pop_valid", CK'(o_tex_req_valid), CK'(1));
        check_eq("after_pop_count", CK'(o_outstanding), CK'(3));
        step();
        i_req_valid = '0;
        check_eq("refill_count", CK'(o_outstanding), CK'(4));
        i_texel_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rand_color();
            step();
        end
        i_texel_valid = 1'b0;
        step();

        // Texel with nothing outstanding is dropped and flagged.
        i_texel_valid = 1'b1;
        rand_color();
        step();
        i_texel_valid = 1'b0;
        #1;
        check_eq("drop_vld", CK'(o_texel_valid), CK'(0));
        check_eq("drop_err", CK'(o_err_unexpected), CK'(1));
        repeat (3) step();
        check_eq("err_sticky", CK'(o_err_unexpected), CK'(1));

        // Reset with requests in flight discards their tags.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("err_cleared", CK'(o_err_unexpected), CK'(0));
        i_req_valid = 4'b0111;
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        repeat (3) step();
        i_req_valid = '0;
        check_eq("inflight_count", CK'(o_outstanding), CK'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_count", CK'(o_outstanding), CK'(0));
        check_eq("midrst_err", CK'(o_err_unexpected), CK'(0));
        i_texel_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_color();
            step();
        end
        i_texel_valid = 1'b0;
        #1;
        check_eq("stale_vld", CK'(o_texel_valid), CK'(0));
        check_eq("stale_err", CK'(o_err_unexpected), CK'(1));
        step();
        step();
        check_eq("grants_done", CK'(exp_grant_q.size()), CK'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
